pulse_qualifier: RTL and testbench
==================================

// Module: pulse_qualifier
// PURPOSE
// Front-end stage upstream of delay_line. Synchronises the raw asynchronous pulse input,
//   rejects glitches, and measures the high width and rising-edge period of each pulse.
// Declares lock once the pulse train is periodic. delay_line consumes pulse_out, rise_stb,
//   width_out, period_out and locked in place of the raw pin.
// PARAMETERS
// SYNC_STAGES  2     synchroniser flops, minimum 2
// FILT_LEN     8     cycles the synced input must differ from pulse_out before pulse_out follows
// CNT_W        16    width/period counter width; saturates at 2^CNT_W-1 (485 us at 135 MHz)
// LOCK_COUNT   4     consecutive in-tolerance periods needed to reach LOCKED
// TOL          16    allowed |period - ref_period| in cycles
// PORTS
// clk_in       in   1      system clock, 135 MHz
// rst_n_in     in   1      asynchronous active-low reset
// in           in   1      raw asynchronous pulse input
// pulse_out    out  1      synchronised, glitch-filtered pulse level
// rise_stb     out  1      one-cycle strobe on each qualified rising edge of pulse_out
// width_out    out  CNT_W  high width of the last pulse in cycles; updated on falling edge
// period_out   out  CNT_W  cycles between the last two rising edges
// meas_valid   out  1      one-cycle strobe when period_out updates
// ovf          out  1      sticky: period counter saturated; cleared by next valid period
// locked       out  1      high in LOCKED state
// BEHAVIOUR
// - Reset: every output 0; counters 0; filter count 0; lock state IDLE; ref_period 0.
// - Latency: pulse_out follows a stable change on in after SYNC_STAGES+FILT_LEN cycles.
//   Latency is equal on both edges, so measured widths are exact.
// - Filter: a counter increments while sync_q != pulse_out and reloads to 0 when they agree.
//   On count == FILT_LEN-1, pulse_out toggles. Excursions shorter than FILT_LEN cycles never
//   reach pulse_out.
// - rise_stb is high in the first cycle that pulse_out is 1.
// - Width counter: starts at 1 in the first high cycle and increments while high, saturating.
//   On the falling edge, width_out is loaded from the count.
// - Period counter: reloads to 1 on rise_stb, otherwise increments and saturates at all-ones.
//   On saturation ovf is set.
// - On rise_stb, period_out is loaded from the period count. If a previous rise has been seen
//   since reset or IDLE, meas_valid is pulsed. A period that is saturated keeps ovf set;
//   any other period clears ovf.
// - Lock FSM (ref_period = last accepted period, match_cnt counts matches):
//   IDLE: on first rise_stb go to ACQ, match_cnt=0. No meas_valid is issued for this edge.
//   ACQ: on meas_valid, if |period - ref| <= TOL then match_cnt++; otherwise match_cnt=0.
//     ref is always loaded from the new period. When match_cnt reaches LOCK_COUNT,
//     go to LOCKED.
//   LOCKED: on meas_valid, if out of tolerance go to ACQ with match_cnt=0 and ref = new period.
//     If in tolerance, ref is updated.
//   Any state: if the period counter reaches saturation, go to IDLE and clear match_cnt.
//     This has priority over a rise_stb in the same cycle; that edge is then treated as the
//     first edge from IDLE.
// - Tolerance compare uses a CNT_W+1-bit signed difference. No wrap-around is possible
//   because the counters saturate.
// - Reset asserted mid-pulse: all state clears immediately. After release, an input that is
//   already high produces a rising edge after filter latency; its width is measured from that
//   edge.
// STRUCTURE
// - Package delay_line_pkg: lock_state_t enum {IDLE, ACQ, LOCKED}; CNT_W default constant;
//   CLK_FREQ = 135_000_000.
// - Sub-module glitch_filter: synchroniser plus filter counter, outputs pulse_out.
//   Parameters SYNC_STAGES and FILT_LEN.
// - Top level: edge detect, width and period counters, lock FSM.
// TESTING (135 MHz clock, default parameters)
// - Reset held, in toggling: all outputs 0. Release with in=0: outputs stay 0, state IDLE.
// - 5-cycle high glitch on in: pulse_out stays 0; no rise_stb.
// - 8-cycle stable high on in: pulse_out rises 10 cycles after the in edge; rise_stb fires once.
// - Train of 1 us high / 10 us low pulses:
//   - width_out = 135 and period_out = 1485.
//   - meas_valid fires from the 2nd edge onward.
//   - locked asserts on the 6th rising edge (4 in-tolerance matches after the ref is set
//     on the 2nd edge).
// - Locked train, then one period of 1485+20: locked drops on that edge. locked re-asserts
//   4 good periods later.
// - in held low for more than 65535 cycles after lock:
//   - ovf is set and the state goes to IDLE; locked=0.
//   - The next pulse gives no meas_valid; the following pulse clears ovf.
// - rst_n_in asserted mid-pulse while locked: all outputs go to 0 asynchronously. After
//   release, lock re-acquires on the normal schedule.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and constants for the pulse front end and the delay line it feeds.
package delay_line_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam int CNT_W_DEFAULT = 16;
    localparam int CLK_FREQ      = 135_000_000;

endpackage

// File: rtl/pulse_qualifier_glitch_filter.sv
// Synchroniser followed by a persistence filter: the output only follows the synced
// input after it has disagreed for FILT_LEN consecutive cycles.
module glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic in,
    output logic pulse_out
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in};
        filt_cnt_d = '0;
        pulse_d    = pulse_q;
        // Toggle on the FILT_LEN-th disagreeing cycle so both edges see equal delay.
        if (sync_bit != pulse_q) begin
            if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
                pulse_d = ~pulse_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q     <= '0;
            filt_cnt_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_cnt_q <= filt_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/pulse_qualifier.sv
// Qualifies the raw pulse pin: filtered level, rising-edge strobe, width/period
// measurement, overflow flag and a lock tracker for periodic trains.
module pulse_qualifier
    import delay_line_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in,
    output logic             pulse_out,
    output logic             rise_stb,
    output logic [CNT_W-1:0] width_out,
    output logic [CNT_W-1:0] period_out,
    output logic             meas_valid,
    output logic             ovf,
    output logic             locked,
    output lock_state_t      lock_state
);

    localparam int               MW      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             filt_pulse;
    logic             pulse_prev_q, pulse_prev_d;
    logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [MW-1:0]    match_q, match_d;
    logic             meas_valid_q, meas_valid_d;
    logic             ovf_q, ovf_d;
    lock_state_t      state_q, state_d;

    logic             rise, fall, sat, meas_now, in_tol;
    logic signed [CNT_W:0] diff;
    logic [CNT_W:0]   abs_diff;

    glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filter (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .in        (in),
        .pulse_out (filt_pulse)
    );

    assign rise = filt_pulse & ~pulse_prev_q;
    assign fall = ~filt_pulse & pulse_prev_q;
    assign sat  = (period_cnt_q == CNT_MAX);
    // A saturated period is never a measurement; that edge restarts acquisition instead.
    assign meas_now = rise && (state_q != IDLE) && !sat;

    assign diff     = $signed({1'b0, period_cnt_q}) - $signed({1'b0, ref_q});
    assign abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign in_tol   = (abs_diff <= (CNT_W + 1)'(TOL));

    always_comb begin
        pulse_prev_d = filt_pulse;
        width_cnt_d  = width_cnt_q;
        if (filt_pulse) begin
            if (rise) begin
                width_cnt_d = CNT_W'(1);
            end else if (width_cnt_q != CNT_MAX) begin
                width_cnt_d = width_cnt_q + 1'b1;
            end
        end
        width_d = fall ? width_cnt_q : width_q;

        period_cnt_d = period_cnt_q;
        if (rise) begin
            period_cnt_d = CNT_W'(1);
        end else if (!sat) begin
            period_cnt_d = period_cnt_q + 1'b1;
        end
        period_d     = rise ? period_cnt_q : period_q;
        meas_valid_d = meas_now;
        ovf_d        = sat ? 1'b1 : (rise ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        ref_d   = ref_q;
        if (sat) begin
            match_d = '0;
            state_d = rise ? ACQ : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = ACQ;
                        match_d = '0;
                    end
                end
                ACQ: begin
                    if (meas_now) begin
                        ref_d = period_cnt_q;
                        if (!in_tol) begin
                            match_d = '0;
                        end else if (match_q == MW'(LOCK_COUNT - 1)) begin
                            match_d = MW'(LOCK_COUNT);
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (meas_now) begin
                        ref_d = period_cnt_q;
                        if (!in_tol) begin
                            state_d = ACQ;
                            match_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pulse_prev_q <= 1'b0;
            width_cnt_q  <= '0;
            width_q      <= '0;
            period_cnt_q <= '0;
            period_q     <= '0;
            ref_q        <= '0;
            match_q      <= '0;
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            state_q      <= IDLE;
        end else begin
            pulse_prev_q <= pulse_prev_d;
            width_cnt_q  <= width_cnt_d;
            width_q      <= width_d;
            period_cnt_q <= period_cnt_d;
            period_q     <= period_d;
            ref_q        <= ref_d;
            match_q      <= match_d;
            meas_valid_q <= meas_valid_d;
            ovf_q        <= ovf_d;
            state_q      <= state_d;
        end
    end

    assign pulse_out  = filt_pulse;
    assign rise_stb   = rise;
    assign width_out  = width_q;
    assign period_out = period_q;
    assign meas_valid = meas_valid_q;
    assign ovf        = ovf_q;
    assign locked     = (state_q == LOCKED);
    assign lock_state = state_q;

endmodule

// File: tb/tb_pulse_qualifier.sv
// Bench for pulse_qualifier: scenario tasks plus a scoreboard that checks every
// width_out update and every meas_valid against expected values queued by the driver.
`timescale 1ns/1ps
module tb_pulse_qualifier;
    import delay_line_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_r = 1'b0;
    logic        pulse_out, rise_stb, meas_valid, ovf, locked;
    logic [15:0] width_out, period_out;
    lock_state_t lock_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_width_q[$];
    logic [15:0] exp_period_q[$];
    int          prev_len = 0;

    int   rise_cnt, meas_cnt, first_meas_edge, lock_edge, unlock_edge;
    logic locked_prev, pulse_last, fall_pend;

    pulse_qualifier dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .in         (in_r),
        .pulse_out  (pulse_out),
        .rise_stb   (rise_stb),
        .width_out  (width_out),
        .period_out (period_out),
        .meas_valid (meas_valid),
        .ovf        (ovf),
        .locked     (locked),
        .lock_state (lock_state)
    );

    always #3.7 clk = ~clk;

    // Monitor / scoreboard, sampling on the inactive edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rise_cnt = 0; meas_cnt = 0; first_meas_edge = 0;
            lock_edge = 0; unlock_edge = 0;
            locked_prev = 1'b0; pulse_last = 1'b0; fall_pend = 1'b0;
        end else begin
            if (fall_pend) begin
                checks++;
                if (exp_width_q.size() == 0) begin
                    errors++;
                    $display("FAIL width_unexpected got=%0d expected=none", width_out);
                end else begin
                    logic [15:0] ew;
                    ew = exp_width_q.pop_front();
                    if (width_out !== ew) begin
                        errors++;
                        $display("FAIL width got=%0d expected=%0d", width_out, ew);
                    end
                end
            end
            fall_pend  = pulse_last && !pulse_out;
            pulse_last = pulse_out;
            if (rise_stb) rise_cnt++;
            if (meas_valid) begin
                meas_cnt++;
                if (first_meas_edge == 0) first_meas_edge = rise_cnt;
                checks++;
                if (exp_period_q.size() == 0) begin
                    errors++;
                    $display("FAIL period_unexpected got=%0d expected=none", period_out);
                end else begin
                    logic [15:0] ep;
                    ep = exp_period_q.pop_front();
                    if (period_out !== ep) begin
                        errors++;
                        $display("FAIL period got=%0d expected=%0d", period_out, ep);
                    end
                end
            end
            if (locked && !locked_prev) lock_edge = rise_cnt;
            if (!locked && locked_prev && unlock_edge == 0) unlock_edge = rise_cnt;
            locked_prev = locked;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_r  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        prev_len = 0;
    endtask

    // One pulse: hi cycles high then lo cycles low, from a negedge.
    task automatic drive_pulse(input int hi, input int lo);
        if (prev_len != 0) exp_period_q.push_back(16'(prev_len));
        exp_width_q.push_back(16'(hi));
        in_r = 1'b1;
        repeat (hi) @(negedge clk);
        in_r = 1'b0;
        repeat (lo) @(negedge clk);
        prev_len = hi + lo;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({pulse_out, rise_stb, meas_valid, ovf, locked} !== 5'b0 ||
            width_out !== 16'd0 || period_out !== 16'd0) begin
            errors++;
            $display("FAIL %s got pulse=%b rise=%b mv=%b ovf=%b lock=%b w=%0d p=%0d expected all 0",
                     tag, pulse_out, rise_stb, meas_valid, ovf, locked, width_out, period_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_r = ~in_r;
        end
        check_all_zero("reset_held");
        in_r = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("after_release");
        checks++;
        if (lock_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state got=%0d expected=%0d", lock_state, IDLE);
        end
    endtask

    task automatic test_glitch();
        int   r0;
        logic seen;
        r0   = rise_cnt;
        seen = 1'b0;
        in_r = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 5) in_r = 1'b0;
            if (pulse_out) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch_pulse got=%b expected=0", seen);
        end
        checks++;
        if (rise_cnt != r0) begin
            errors++;
            $display("FAIL glitch_rise got=%0d expected=%0d", rise_cnt, r0);
        end
    endtask

    task automatic test_latency();
        int r0, lat;
        r0  = rise_cnt;
        lat = 0;
        exp_width_q.push_back(16'd8);
        in_r = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 8) in_r = 1'b0;
            if (pulse_out && lat == 0) lat = i;
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL latency got=%0d expected=10", lat);
        end
        checks++;
        if (rise_cnt != r0 + 1) begin
            errors++;
            $display("FAIL latency_rise_count got=%0d expected=%0d", rise_cnt, r0 + 1);
        end
        checks++;
        if (meas_cnt != 0 || lock_state !== ACQ) begin
            errors++;
            $display("FAIL first_edge got meas=%0d state=%0d expected meas=0 state=%0d",
                     meas_cnt, lock_state, ACQ);
        end
    endtask

    task automatic test_train();
        do_reset();
        for (int p = 0; p < 7; p++) drive_pulse(135, 1350);
        checks++;
        if (first_meas_edge != 2) begin
            errors++;
            $display("FAIL first_meas_edge got=%0d expected=2", first_meas_edge);
        end
        checks++;
        if (meas_cnt != 6) begin
            errors++;
            $display("FAIL train_meas_count got=%0d expected=6", meas_cnt);
        end
        checks++;
        if (lock_edge != 6 || locked !== 1'b1) begin
            errors++;
            $display("FAIL train_lock_edge got=%0d locked=%b expected=6 locked=1", lock_edge, locked);
        end
    endtask

    // Edge 9: 1501 vs 1485 (diff 16, kept). Edge 10: 1485 vs 1501 (kept).
    // Edge 11: 1505 vs 1485 (diff 20, drop). Edge 12: 1485 vs 1505 (miss). 13..16 match.
    task automatic test_unlock();
        drive_pulse(135, 1366);
        drive_pulse(135, 1350);
        drive_pulse(135, 1370);
        for (int p = 0; p < 7; p++) drive_pulse(135, 1350);
        checks++;
        if (unlock_edge != 11) begin
            errors++;
            $display("FAIL unlock_edge got=%0d expected=11", unlock_edge);
        end
        checks++;
        if (lock_edge != 16 || locked !== 1'b1) begin
            errors++;
            $display("FAIL relock_edge got=%0d locked=%b expected=16 locked=1", lock_edge, locked);
        end
    endtask

    task automatic test_reset_mid_pulse();
        if (prev_len != 0) exp_period_q.push_back(16'(prev_len));
        in_r = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (locked !== 1'b1 || pulse_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got locked=%b pulse=%b expected 1 1", locked, pulse_out);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        prev_len = 0;
        exp_width_q.push_back(16'd60);
        repeat (60) @(negedge clk);
        in_r = 1'b0;
        repeat (240) @(negedge clk);
        prev_len = 300;
        for (int p = 0; p < 6; p++) drive_pulse(40, 260);
        checks++;
        if (lock_edge != 6 || locked !== 1'b1) begin
            errors++;
            $display("FAIL reset_relock got=%0d locked=%b expected=6 locked=1", lock_edge, locked);
        end
    endtask

    task automatic test_ovf();
        int m0;
        repeat (65535 + 100) @(negedge clk);
        prev_len = 0;
        checks++;
        if (ovf !== 1'b1 || locked !== 1'b0 || lock_state !== IDLE) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b locked=%b state=%0d expected 1 0 %0d",
                     ovf, locked, lock_state, IDLE);
        end
        m0 = meas_cnt;
        drive_pulse(40, 260);
        checks++;
        if (meas_cnt != m0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_next_pulse got meas=%0d ovf=%b expected meas=%0d ovf=1", meas_cnt, ovf, m0);
        end
        drive_pulse(40, 260);
        checks++;
        if (meas_cnt != m0 + 1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got meas=%0d ovf=%b expected meas=%0d ovf=0", meas_cnt, ovf, m0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latency();
        test_train();
        test_unlock();
        test_reset_mid_pulse();
        test_ovf();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_width_q.size() != 0 || exp_period_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got widths=%0d periods=%0d expected 0 0",
                     exp_width_q.size(), exp_period_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
